// File: rtl/cv32e40s_pkg.sv
// Shared types, Zcmp field constants and encoding helpers for the Zc sequencer.
package cv32e40s_pkg;

  typedef enum logic [2:0] {
    SEQ_PUSH,
    SEQ_POP,
    SEQ_POPRET,
    SEQ_POPRETZ,
    SEQ_MVSA,
    SEQ_MVA,
    SEQ_NONE
  } seq_instr_e;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_RUN
  } seq_state_e;

  localparam logic [1:0] ZC_OP_C2     = 2'b10;
  localparam logic [2:0] ZC_FUNCT3    = 3'b101;
  localparam logic [4:0] ZC_PUSH      = 5'b11000;
  localparam logic [4:0] ZC_POP       = 5'b11010;
  localparam logic [4:0] ZC_POPRETZ   = 5'b11100;
  localparam logic [4:0] ZC_POPRET    = 5'b11110;
  localparam logic [2:0] ZC_MV_FUNCT  = 3'b011;
  localparam logic [1:0] ZC_MVSA01    = 2'b01;
  localparam logic [1:0] ZC_MVA01S    = 2'b11;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam logic [4:0] REG_RA       = 5'd1;
  localparam logic [4:0] REG_SP       = 5'd2;
  localparam logic [4:0] REG_A0       = 5'd10;
  localparam logic [4:0] REG_A1       = 5'd11;

  // r' 0..1 -> s0..s1 (x8..x9), 2..7 -> s2..s7 (x18..x23)
  function automatic logic [4:0] sreg_map(input logic [2:0] r);
    return (r < 3'd2) ? {4'b0100, r[0]} : {2'b10, r};
  endfunction

  // Ascending register list position: 0 = ra, 1 = s0, 2 = s1, 3..12 = s2..s11
  function automatic logic [4:0] rlist_reg(input logic [3:0] idx);
    logic [4:0] r;
    if (idx == 4'd0)      r = REG_RA;
    else if (idx == 4'd1) r = 5'd8;
    else if (idx == 4'd2) r = 5'd9;
    else                  r = {1'b0, idx} + 5'd15;
    return r;
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
  endfunction

endpackage

// File: rtl/cv32e40s_zc_expand.sv
// Combinational Zcmp expander: maps (compressed instruction, step) to one RV32I micro-op.
module cv32e40s_zc_expand
  import cv32e40s_pkg::*;
(
  input  logic [15:0] instr_i,
  input  logic [3:0]  step_i,
  output logic [31:0] uop_o,
  output logic [4:0]  count_o,
  output logic        last_o,
  output logic        is_seq_o
);

  seq_instr_e  kind;
  logic        legal;
  logic [3:0]  rlist;
  logic [1:0]  spimm;
  logic [2:0]  r1s;
  logic [2:0]  r2s;
  logic [4:0]  nregs;
  logic [6:0]  base;
  logic [6:0]  adj;
  logic [11:0] adj12;
  logic [11:0] off12;
  logic [4:0]  step5;
  logic [4:0]  stp1;
  logic [3:0]  ridx;

  assign rlist = instr_i[7:4];
  assign spimm = instr_i[3:2];
  assign r1s   = instr_i[9:7];
  assign r2s   = instr_i[4:2];
  assign step5 = {1'b0, step_i};
  assign stp1  = step5 + 5'd1;
  assign off12 = {5'b0, stp1, 2'b00};

  always_comb begin
    kind  = SEQ_NONE;
    legal = 1'b0;
    if (instr_i[1:0] == ZC_OP_C2 && instr_i[15:13] == ZC_FUNCT3) begin
      if (instr_i[12:8] == ZC_PUSH)         kind = SEQ_PUSH;
      else if (instr_i[12:8] == ZC_POP)     kind = SEQ_POP;
      else if (instr_i[12:8] == ZC_POPRETZ) kind = SEQ_POPRETZ;
      else if (instr_i[12:8] == ZC_POPRET)  kind = SEQ_POPRET;
      else if (instr_i[12:10] == ZC_MV_FUNCT && instr_i[6:5] == ZC_MVSA01) kind = SEQ_MVSA;
      else if (instr_i[12:10] == ZC_MV_FUNCT && instr_i[6:5] == ZC_MVA01S) kind = SEQ_MVA;
    end
    case (kind)
      SEQ_PUSH, SEQ_POP, SEQ_POPRET, SEQ_POPRETZ: legal = (rlist >= 4'd4);
      SEQ_MVSA:                                   legal = (r1s != r2s);
      SEQ_MVA:                                    legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
  end

  assign is_seq_o = legal;

  // rlist 15 adds s10 and s11 together, so it holds 13 registers rather than 12
  assign nregs = (rlist == 4'd15) ? 5'd13 : ({1'b0, rlist} - 5'd3);
  assign ridx  = nregs[3:0] - 4'd1 - step_i;

  always_comb begin
    if (rlist == 4'd15)       base = 7'd64;
    else if (rlist >= 4'd12)  base = 7'd48;
    else if (rlist >= 4'd8)   base = 7'd32;
    else                      base = 7'd16;
  end

  assign adj   = base + {1'b0, spimm, 4'b0000};
  assign adj12 = {5'b0, adj};

  always_comb begin
    case (kind)
      SEQ_PUSH, SEQ_POP: count_o = nregs + 5'd1;
      SEQ_POPRET:        count_o = nregs + 5'd2;
      SEQ_POPRETZ:       count_o = nregs + 5'd3;
      SEQ_MVSA, SEQ_MVA: count_o = 5'd2;
      default:           count_o = 5'd1;
    endcase
  end

  assign last_o = (step5 == count_o - 5'd1);

  always_comb begin
    uop_o = enc_i(12'd0, REG_ZERO, 3'b000, REG_ZERO, OPC_OPIMM);
    case (kind)
      SEQ_PUSH, SEQ_POP, SEQ_POPRET, SEQ_POPRETZ: begin
        if (step5 < nregs) begin
          if (kind == SEQ_PUSH) uop_o = enc_sw(12'd0 - off12, rlist_reg(ridx), REG_SP);
          else                  uop_o = enc_i(adj12 - off12, REG_SP, 3'b010, rlist_reg(ridx), OPC_LOAD);
        end else if (step5 == nregs) begin
          uop_o = enc_i((kind == SEQ_PUSH) ? (12'd0 - adj12) : adj12, REG_SP, 3'b000, REG_SP, OPC_OPIMM);
        end else if (step5 == nregs + 5'd1 && kind == SEQ_POPRETZ) begin
          uop_o = enc_i(12'd0, REG_ZERO, 3'b000, REG_A0, OPC_OPIMM);
        end else begin
          uop_o = enc_i(12'd0, REG_RA, 3'b000, REG_ZERO, OPC_JALR);
        end
      end
      SEQ_MVSA: begin
        if (step_i == 4'd0) uop_o = enc_i(12'd0, REG_A0, 3'b000, sreg_map(r1s), OPC_OPIMM);
        else                uop_o = enc_i(12'd0, REG_A1, 3'b000, sreg_map(r2s), OPC_OPIMM);
      end
      SEQ_MVA: begin
        if (step_i == 4'd0) uop_o = enc_i(12'd0, sreg_map(r1s), 3'b000, REG_A0, OPC_OPIMM);
        else                uop_o = enc_i(12'd0, sreg_map(r2s), 3'b000, REG_A1, OPC_OPIMM);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cv32e40s_zc_sequencer.sv
// IF-stage Zcmp sequencer: streams push/pop/mv micro-ops to IF/ID, passes everything else through.
module cv32e40s_zc_sequencer
  import cv32e40s_pkg::*;
#(
  parameter int ZC_EXT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        halt_i,
  input  logic        kill_i,
  output logic        seq_valid_o,
  output logic        seq_first_o,
  output logic        seq_last_o,
  output logic        seq_tbljmp_o,
  output seq_state_e  dbg_state_o,
  output logic [3:0]  dbg_step_o
);

  seq_state_e  state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [31:0] exp_uop;
  logic [4:0]  exp_count;
  logic        exp_last;
  logic        exp_is_seq;
  logic        seq_hit;
  logic        seq_active;
  logic        handshake;

  cv32e40s_zc_expand u_expand (
    .instr_i  (instr_i[15:0]),
    .step_i   (step_q),
    .uop_o    (exp_uop),
    .count_o  (exp_count),
    .last_o   (exp_last),
    .is_seq_o (exp_is_seq)
  );

  assign seq_hit    = (ZC_EXT != 0) && exp_is_seq;
  assign seq_active = seq_hit && instr_valid_i;

  // Handshake: an op transfers when valid_o && ready_i. The aligner's instruction
  // is consumed (instr_ready_o) only with the transfer of the last micro-op, never
  // in a kill cycle; pass-through consumes whenever IF/ID is ready and not halted.
  assign valid_o       = instr_valid_i && !halt_i;
  assign handshake     = valid_o && ready_i;
  assign instr_o       = seq_active ? exp_uop : instr_i;
  assign instr_ready_o = seq_active ? (handshake && exp_last && !kill_i) : (ready_i && !halt_i);
  assign seq_valid_o   = seq_active;
  assign seq_first_o   = seq_active && (step_q == 4'd0);
  assign seq_last_o    = seq_active && exp_last;
  assign seq_tbljmp_o  = 1'b0;
  assign dbg_state_o   = state_q;
  assign dbg_step_o    = step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      step_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (kill_i) begin
      state_d = SEQ_IDLE;
      step_d  = 4'd0;
    end else if (seq_active && handshake) begin
      if (exp_last) begin
        state_d = SEQ_IDLE;
        step_d  = 4'd0;
      end else begin
        state_d = SEQ_RUN;
        step_d  = step_q + 4'd1;
      end
    end
  end

  a_instr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == SEQ_RUN && !kill_i) |-> $stable(instr_i));

  a_step_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == SEQ_RUN && instr_valid_i) |-> ({1'b0, step_q} < exp_count));

endmodule

// File: tb/tb_cv32e40s_zc_sequencer.sv
// Self-checking bench for the Zcmp sequencer: directed spec scenarios plus randomized traffic.
module tb_cv32e40s_zc_sequencer;
  import cv32e40s_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_i = 32'd0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        kill_i = 1'b0;
  logic        seq_valid_o;
  logic        seq_first_o;
  logic        seq_last_o;
  logic        seq_tbljmp_o;
  seq_state_e  dbg_state_o;
  logic [3:0]  dbg_step_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  cv32e40s_zc_sequencer #(.ZC_EXT(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .halt_i        (halt_i),
    .kill_i        (kill_i),
    .seq_valid_o   (seq_valid_o),
    .seq_first_o   (seq_first_o),
    .seq_last_o    (seq_last_o),
    .seq_tbljmp_o  (seq_tbljmp_o),
    .dbg_state_o   (dbg_state_o),
    .dbg_step_o    (dbg_step_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_i(input int rd, input int rs1, input int f3, input int imm, input int opc);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
  endfunction

  function automatic logic [31:0] m_sw(input int rs2, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'd2, 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic int m_sreg(input int r);
    return (r < 2) ? 8 + r : 16 + r;
  endfunction

  // Fills exp_q with the micro-op stream for ins; returns 1 if it is sequenced.
  function automatic bit build_expected(input logic [31:0] ins);
    logic [15:0] c;
    int rl, spi, n, adj, r1, r2;
    int regs[13];
    bit is_push, is_popret, is_popretz;
    regs = '{1, 8, 9, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27};
    c = ins[15:0];
    exp_q.delete();
    if (c[1:0] == 2'b10 && c[15:13] == 3'b101) begin
      is_push    = (c[12:8] == 5'b11000);
      is_popretz = (c[12:8] == 5'b11100);
      is_popret  = (c[12:8] == 5'b11110);
      if (is_push || is_popret || is_popretz || c[12:8] == 5'b11010) begin
        rl  = int'(c[7:4]);
        spi = int'(c[3:2]);
        if (rl >= 4) begin
          n   = (rl == 15) ? 13 : rl - 3;
          adj = ((rl <= 7) ? 16 : (rl <= 11) ? 32 : (rl <= 14) ? 48 : 64) + 16 * spi;
          for (int j = 1; j <= n; j++) begin
            if (is_push) exp_q.push_back(m_sw(regs[n - j], -4 * j));
            else         exp_q.push_back(m_i(regs[n - j], 2, 2, adj - 4 * j, 'h03));
          end
          exp_q.push_back(m_i(2, 2, 0, is_push ? -adj : adj, 'h13));
          if (is_popretz) exp_q.push_back(m_i(10, 0, 0, 0, 'h13));
          if (is_popretz || is_popret) exp_q.push_back(m_i(0, 1, 0, 0, 'h67));
          return 1'b1;
        end
      end else if (c[12:10] == 3'b011 && c[5] == 1'b1) begin
        r1 = m_sreg(int'(c[9:7]));
        r2 = m_sreg(int'(c[4:2]));
        if (c[6] == 1'b0 && r1 != r2) begin
          exp_q.push_back(m_i(r1, 10, 0, 0, 'h13));
          exp_q.push_back(m_i(r2, 11, 0, 0, 'h13));
          return 1'b1;
        end else if (c[6] == 1'b1) begin
          exp_q.push_back(m_i(10, r1, 0, 0, 'h13));
          exp_q.push_back(m_i(11, r2, 0, 0, 'h13));
          return 1'b1;
        end
      end
    end
    exp_q.push_back(ins);
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] f5s[4];
    logic [15:0] c;
    f5s = '{5'b11000, 5'b11010, 5'b11100, 5'b11110};
    case ($urandom_range(0, 4))
      0, 1: c = {3'b101, f5s[$urandom_range(0, 3)], 4'($urandom_range(4, 15)), 2'($urandom_range(0, 3)), 2'b10};
      2:    c = {3'b101, 3'b011, 3'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11,
                 3'($urandom_range(0, 7)), 2'b10};
      3:    c = {3'b101, f5s[$urandom_range(0, 3)], 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b10};
      default: return $urandom;
    endcase
    return {16'($urandom), c};
  endfunction

  // ---------------- driver ----------------
  // ready_mode 0: always ready, 1: random, 2: pattern 1,0,0,1
  // halt_mode 0: none, 1: halt on cycles 1-2, 2: random
  task automatic send(input logic [31:0] ins, input bit is_seq, input int ready_mode,
                      input int halt_mode, input int stop_after);
    int idx;
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    instr_i = ins;
    instr_valid_i = 1'b1;
    while (exp_q.size() != 0 && idx != stop_after && cyc < 400) begin
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = ($urandom_range(0, 3) != 0);
        default: ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      case (halt_mode)
        0:       halt_i = 1'b0;
        1:       halt_i = (cyc == 1) || (cyc == 2);
        default: halt_i = ($urandom_range(0, 5) == 0);
      endcase
      acc = ready_i && !halt_i;
      @(negedge clk);
      check("valid_o", valid_o, !halt_i);
      check("instr_o", instr_o, exp_q[0]);
      check("seq_valid", seq_valid_o, is_seq);
      check("seq_first", seq_first_o, is_seq && idx == 0);
      check("seq_last", seq_last_o, is_seq && exp_q.size() == 1);
      check("instr_ready", instr_ready_o, is_seq ? (acc && exp_q.size() == 1) : acc);
      check("step", dbg_step_o, is_seq ? idx : 0);
      check("tbljmp", seq_tbljmp_o, 0);
      @(posedge clk);
      #1;
      if (acc) begin
        void'(exp_q.pop_front());
        idx++;
      end
      cyc++;
    end
    halt_i = 1'b0;
    if (idx != stop_after && exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit s;
    logic [31:0] ins;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_seq_valid", seq_valid_o, 0);
    check("rst_first", seq_first_o, 0);
    check("rst_last", seq_last_o, 0);
    check("rst_state", dbg_state_o, SEQ_IDLE);
    check("rst_step", dbg_step_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // push {ra,s0,s1}, spimm=1
    exp_q = '{32'hFE912E23, 32'hFE812C23, 32'hFE112A23, 32'hFE010113};
    send(32'h0000B866, 1'b1, 0, 0, -1);
    check("push_end_step", dbg_step_o, 0);

    // popretz {ra,s0}, spimm=0
    exp_q = '{32'h00C12403, 32'h00812083, 32'h01010113, 32'h00000513, 32'h00008067};
    send(32'h0000BC52, 1'b1, 0, 0, -1);
    check("popretz_end_step", dbg_step_o, 0);
    check("popretz_end_state", dbg_state_o, SEQ_IDLE);

    // mvsa01 s0,s2
    exp_q = '{32'h00050413, 32'h00058913};
    send(32'h0000AC2A, 1'b1, 0, 0, -1);

    // mvsa01 with r1s'==r2s' is not sequenced
    exp_q = '{32'h0000ACA6};
    send(32'h0000ACA6, 1'b0, 0, 0, -1);

    // push rlist=15: 13 stores plus the sp adjust, ready toggling 1,0,0,1
    s = build_expected(32'h0000B8F2);
    check("model_push15_len", exp_q.size(), 14);
    send(32'h0000B8F2, s, 2, 0, -1);

    // halt mid-sequence
    s = build_expected(32'h0000B866);
    send(32'h0000B866, s, 0, 1, -1);

    // kill together with the handshake of op2 of a pop
    s = build_expected(32'h0000BA76);
    send(32'h0000BA76, s, 0, 0, 2);
    ready_i = 1'b1;
    kill_i = 1'b1;
    @(negedge clk);
    check("kill_instr_o", instr_o, exp_q[0]);
    check("kill_instr_ready", instr_ready_o, 0);
    check("kill_step_before", dbg_step_o, 2);
    @(posedge clk);
    #1 kill_i = 1'b0;
    check("kill_step_after", dbg_step_o, 0);
    check("kill_state_after", dbg_state_o, SEQ_IDLE);
    s = build_expected(32'h0000BA76);
    send(32'h0000BA76, s, 0, 0, -1);

    // async reset during step 3 of a push
    s = build_expected(32'h0000B866);
    send(32'h0000B866, s, 0, 0, 3);
    ready_i = 1'b0;
    check("pre_reset_step", dbg_step_o, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_step", dbg_step_o, 0);
    check("mid_rst_state", dbg_state_o, SEQ_IDLE);
    check("mid_rst_instr_o", instr_o, 32'hFE912E23);
    check("mid_rst_first", seq_first_o, 1);
    instr_valid_i = 1'b0;
    #1;
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_seq_valid", seq_valid_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // non-Zcmp pass-through
    exp_q = '{32'h00A50533};
    send(32'h00A50533, 1'b0, 0, 0, -1);

    // randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      ins = rand_instr();
      s = build_expected(ins);
      send(ins, s, 1, 2, -1);
      if ($urandom_range(0, 3) == 0) begin
        instr_valid_i = 1'b0;
        @(negedge clk);
        check("idle_valid", valid_o, 0);
        check("idle_seq_valid", seq_valid_o, 0);
        @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
